mandelbrot_iter_ctrl: RTL and testbench

MANDELBROT_ITER_CTRL -- requirements
Module: mandelbrot_iter_ctrl

---
 rtl/mandelbrot_iter_ctrl.sv | 121 ++++++++++++
 tb/tb_mandelbrot_iter_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iter_ctrl.sv
// Iteration controller for a Mandelbrot pixel: owns z, c and the iteration count,
// and drives an external combinational z^2+c datapath one step per cycle.
module mandelbrot_iter_ctrl #(
    parameter int FIXED_POINT_WIDTH = 16,
    parameter int ITER_WIDTH        = 8,
    parameter int MAX_ITER          = 255
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [FIXED_POINT_WIDTH-1:0] c_real,
    input  logic [FIXED_POINT_WIDTH-1:0] c_imaginary,
    input  logic                         abort,
    output logic [FIXED_POINT_WIDTH-1:0] z_real,
    output logic [FIXED_POINT_WIDTH-1:0] z_imaginary,
    output logic [FIXED_POINT_WIDTH-1:0] dp_c_real,
    output logic [FIXED_POINT_WIDTH-1:0] dp_c_imaginary,
    input  logic [FIXED_POINT_WIDTH-1:0] new_z_real,
    input  logic [FIXED_POINT_WIDTH-1:0] new_z_imaginary,
    input  logic                         is_mandelbrot,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [ITER_WIDTH-1:0]        iter_count,
    output logic                         escaped,
    output logic                         busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready depends only on the controller state, never on the partner's valid.

    localparam logic [ITER_WIDTH-1:0] MAX_COUNT = ITER_WIDTH'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ITER_WIDTH-1:0] count;
    logic                  accept;
    logic                  update;
    logic                  finish;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        update     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    accept     = 1'b1;
                    next_state = ITER;
                end
            end
            ITER: begin
                // abort beats escape, escape beats the iteration limit
                if (abort) begin
                    next_state = IDLE;
                end else if (!is_mandelbrot || count == MAX_COUNT) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end else begin
                    update = 1'b1;
                end
            end
            DONE: begin
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            z_real         <= '0;
            z_imaginary    <= '0;
            dp_c_real      <= '0;
            dp_c_imaginary <= '0;
            count          <= '0;
            iter_count     <= '0;
            escaped        <= 1'b0;
        end else begin
            if (accept) begin
                dp_c_real      <= c_real;
                dp_c_imaginary <= c_imaginary;
                z_real         <= '0;
                z_imaginary    <= '0;
                count          <= '0;
            end
            if (update) begin
                z_real      <= new_z_real;
                z_imaginary <= new_z_imaginary;
                count       <= count + 1'b1;
            end
            // count equals MAX_ITER whenever the limit ends the point
            if (finish) begin
                iter_count <= count;
                escaped    <= !is_mandelbrot;
            end
        end
    end

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Directed bench for mandelbrot_iter_ctrl with a behavioural Q4.12 z^2+c datapath.
module tb_mandelbrot_iter_ctrl;

    localparam int W = 16;
    localparam int IW = 8;
    localparam int MAXI = 255;

    logic          clk;
    logic          nrst;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  c_real;
    logic [W-1:0]  c_imaginary;
    logic          abort;
    logic [W-1:0]  z_real;
    logic [W-1:0]  z_imaginary;
    logic [W-1:0]  dp_c_real;
    logic [W-1:0]  dp_c_imaginary;
    logic [W-1:0]  new_z_real;
    logic [W-1:0]  new_z_imaginary;
    logic          is_mandelbrot;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] iter_count;
    logic          escaped;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mandelbrot_iter_ctrl #(
        .FIXED_POINT_WIDTH(W),
        .ITER_WIDTH(IW),
        .MAX_ITER(MAXI)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .c_real(c_real),
        .c_imaginary(c_imaginary),
        .abort(abort),
        .z_real(z_real),
        .z_imaginary(z_imaginary),
        .dp_c_real(dp_c_real),
        .dp_c_imaginary(dp_c_imaginary),
        .new_z_real(new_z_real),
        .new_z_imaginary(new_z_imaginary),
        .is_mandelbrot(is_mandelbrot),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .iter_count(iter_count),
        .escaped(escaped),
        .busy(busy)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q4.12 datapath: z^2 + c, escape flag from |z|^2 < 4
    logic signed [63:0] zr, zi, cr, ci, nr, ni, mag;
    always_comb begin
        zr  = 64'(signed'(z_real));
        zi  = 64'(signed'(z_imaginary));
        cr  = 64'(signed'(dp_c_real));
        ci  = 64'(signed'(dp_c_imaginary));
        nr  = ((zr * zr - zi * zi) >>> 12) + cr;
        ni  = ((2 * zr * zi) >>> 12) + ci;
        mag = zr * zr + zi * zi;
        new_z_real      = nr[W-1:0];
        new_z_imaginary = ni[W-1:0];
        is_mandelbrot   = (mag < (64'sd4 <<< 24));
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Driver tasks: all leave the caller just after a falling edge.
    task automatic accept_point(input logic [W-1:0] cre, input logic [W-1:0] cim);
        @(negedge clk);
        start_valid = 1'b1;
        c_real      = cre;
        c_imaginary = cim;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic wait_result(input int start, output int cycles);
        cycles = start;
        while (!result_valid && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume(input string tag);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(start_ready), 32'd1);
    endtask

    task automatic run_point(input string tag, input logic [W-1:0] cre, input logic [W-1:0] cim,
                             input int lat, input int it, input logic esc);
        int cyc;
        accept_point(cre, cim);
        wait_result(0, cyc);
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_iter"}, 32'(iter_count), 32'(it));
        check({tag, "_escaped"}, 32'(escaped), 32'(esc));
        consume(tag);
    endtask

    initial begin
        int cyc;
        int seen;
        nrst         = 1'b0;
        start_valid  = 1'b0;
        c_real       = '0;
        c_imaginary  = '0;
        abort        = 1'b0;
        result_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_z", {z_real, z_imaginary}, 32'd0);
        check("rst_c", {dp_c_real, dp_c_imaginary}, 32'd0);
        check("rst_result", {23'd0, escaped, iter_count}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);

        run_point("c_zero", 16'h0000, 16'h0000, 256, 255, 1'b0);
        run_point("c_two", 16'h2000, 16'h0000, 2, 1, 1'b1);
        run_point("c_one_i", 16'h1000, 16'h1000, 3, 2, 1'b1);
        run_point("c_half", 16'h0800, 16'h0000, 6, 5, 1'b1);

        // c = -1.0: z goes 0, -1, 0, -1 ...
        accept_point(16'hF000, 16'h0000);
        check("neg1_dp_c", 32'(dp_c_real), 32'h0000F000);
        @(negedge clk);
        check("neg1_z1", 32'(z_real), 32'h0000F000);
        @(negedge clk);
        check("neg1_z2", 32'(z_real), 32'h00000000);
        wait_result(2, cyc);
        check("neg1_latency", 32'(cyc), 32'd256);
        check("neg1_iter", 32'(iter_count), 32'd255);
        check("neg1_escaped", 32'(escaped), 32'd0);
        consume("neg1");

        // Backpressure: result held, new point and abort must be ignored in DONE
        accept_point(16'h2000, 16'h0000);
        wait_result(0, cyc);
        check("bp_latency", 32'(cyc), 32'd2);
        check("bp_z_hold", 32'(z_real), 32'h00002000);
        check("bp_c_hold", 32'(dp_c_real), 32'h00002000);
        start_valid = 1'b1;
        c_real      = 16'h0000;
        abort       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(result_valid), 32'd1);
            check("bp_iter", 32'(iter_count), 32'd1);
            check("bp_escaped", 32'(escaped), 32'd1);
            check("bp_start_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        abort       = 1'b0;
        consume("bp");

        // Abort at count 5
        accept_point(16'h0000, 16'h0000);
        repeat (5) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_start_ready", 32'(start_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (result_valid) seen++;
            @(negedge clk);
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_point("after_abort", 16'h2000, 16'h0000, 2, 1, 1'b1);

        // Reset at count 100
        accept_point(16'h0000, 16'h0000);
        repeat (100) @(negedge clk);
        check("rst100_z", 32'(z_real), 32'd0);
        check("rst100_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        check("rst100_busy_low", 32'(busy), 32'd0);
        check("rst100_valid", 32'(result_valid), 32'd0);
        check("rst100_c", {dp_c_real, dp_c_imaginary}, 32'd0);
        check("rst100_result", {23'd0, escaped, iter_count}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("rst100_start_ready", 32'(start_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid || busy) seen++;
        end
        check("rst100_no_result", 32'(seen), 32'd0);
        run_point("after_rst", 16'h1000, 16'h1000, 3, 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
